// File: rtl/rv_multicycle_ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control FSM.
// Imported by the opcode decoder and the controller top.
package rv_ctrl_pkg;

  typedef logic [2:0] ctrl_state_t;
  localparam ctrl_state_t ST_FETCH  = 3'd0;
  localparam ctrl_state_t ST_DECODE = 3'd1;
  localparam ctrl_state_t ST_EXEC   = 3'd2;
  localparam ctrl_state_t ST_MEM    = 3'd3;
  localparam ctrl_state_t ST_WB     = 3'd4;
  localparam ctrl_state_t ST_TRAP   = 3'd5;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_fmt_t;

  typedef enum logic [3:0] {
    CLS_LOAD,
    CLS_STORE,
    CLS_OPIMM,
    CLS_OP,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_ALU   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// Unified instruction/data memory handshake between controller and memory.
interface rv_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ready);
endinterface

// File: rtl/rv_multicycle_ctrl_decode.sv
// Combinational opcode classifier: legality, instruction class and immediate format.
module rv_opcode_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       legal,
  output op_class_t  cls,
  output imm_fmt_t   imm_fmt
);

  always_comb begin
    legal   = 1'b1;
    cls     = CLS_ILLEGAL;
    imm_fmt = IMM_I;
    case (opcode)
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  begin cls = CLS_STORE;  imm_fmt = IMM_S; end
      OPC_OPIMM:  cls = CLS_OPIMM;
      OPC_OP:     cls = CLS_OP;
      OPC_BRANCH: begin cls = CLS_BRANCH; imm_fmt = IMM_B; end
      OPC_JAL:    begin cls = CLS_JAL;    imm_fmt = IMM_J; end
      OPC_JALR:   cls = CLS_JALR;
      OPC_LUI:    begin cls = CLS_LUI;    imm_fmt = IMM_U; end
      OPC_AUIPC:  begin cls = CLS_AUIPC;  imm_fmt = IMM_U; end
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/exec/mem/wb over a shared
// datapath, counts retired instructions and traps on illegal opcodes or memory timeouts.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic                     rd_zero,
  input  logic                     branch_taken,
  rv_multicycle_ctrl_if.master     mem,
  output logic                     ir_we,
  output logic                     pc_we,
  output logic [1:0]               pc_sel,
  output logic                     alu_src_a,
  output logic                     alu_src_b,
  output logic [2:0]               imm_sel,
  output logic                     reg_we,
  output logic [1:0]               wb_sel,
  output logic                     trap,
  output logic [CNT_W-1:0]         instret
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  ctrl_state_t      state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] instret_q;
  logic             boot_q;
  logic             req, we, asel, retire;

  logic      dec_legal;
  op_class_t dec_cls;
  imm_fmt_t  dec_imm;

  // funct3 is carried for the datapath; control sequencing does not depend on it.
  logic unused_funct3;
  assign unused_funct3 = ^funct3;

  rv_opcode_decode u_decode (
    .opcode  (opcode),
    .legal   (dec_legal),
    .cls     (dec_cls),
    .imm_fmt (dec_imm)
  );

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    req       = 1'b0;
    we        = 1'b0;
    asel      = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    imm_sel   = dec_imm;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;

    // The reset cycle and the one after stay fully quiet; late mem_ready is dropped.
    if (!(rst || boot_q)) begin
      case (state_q)
        ST_FETCH: begin
          req = 1'b1;
          if (mem.mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: state_d = dec_legal ? ST_EXEC : ST_TRAP;
        ST_EXEC: begin
          alu_src_b = (dec_cls != CLS_OP);
          unique case (dec_cls)
            CLS_LOAD, CLS_STORE: state_d = ST_MEM;
            CLS_OPIMM, CLS_OP, CLS_LUI: state_d = ST_WB;
            CLS_AUIPC: begin
              alu_src_a = 1'b1;
              state_d   = ST_WB;
            end
            CLS_BRANCH: begin
              alu_src_a = 1'b1;
              pc_we     = branch_taken;
              pc_sel    = PC_ALU;
              state_d   = ST_FETCH;
            end
            CLS_JAL: begin
              alu_src_a = 1'b1;
              pc_we     = 1'b1;
              pc_sel    = PC_ALU;
              state_d   = ST_WB;
            end
            CLS_JALR: begin
              pc_we   = 1'b1;
              pc_sel  = PC_JALR;
              state_d = ST_WB;
            end
            default: state_d = ST_TRAP;
          endcase
        end
        ST_MEM: begin
          req  = 1'b1;
          asel = 1'b1;
          we   = (dec_cls == CLS_STORE);
          if (mem.mem_ready) state_d = (dec_cls == CLS_STORE) ? ST_FETCH : ST_WB;
        end
        ST_WB: begin
          reg_we = ~rd_zero;
          case (dec_cls)
            CLS_LOAD:          wb_sel = WB_MEM;
            CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
            CLS_LUI:           wb_sel = WB_IMM;
            default:           wb_sel = WB_ALU;
          endcase
          state_d = ST_FETCH;
        end
        ST_TRAP: state_d = ST_TRAP;
        default: state_d = ST_TRAP;
      endcase

      if (req && !mem.mem_ready) begin
        wait_d = wait_q + WaitW'(1);
        if (wait_q == WaitW'(TIMEOUT - 1)) state_d = ST_TRAP;
      end
      if ((state_d != state_q) && (state_d == ST_FETCH || state_d == ST_MEM)) begin
        wait_d = '0;
      end
    end

    retire = (state_d == ST_FETCH) && (state_q inside {ST_EXEC, ST_MEM, ST_WB});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
      boot_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      boot_q  <= 1'b0;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign mem.mem_req  = req;
  assign mem.mem_we   = we;
  assign mem.addr_sel = asel;
  assign trap         = (state_q == ST_TRAP);
  assign instret      = instret_q;

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
Control FSM that sequences the shared RV32I datapath (register file, ALU, immediate generator, single memory port) over multiple cycles per instruction. It drives the enables and mux selects for each instruction phase, handshakes with the unified instruction/data memory, and selects the immediate format for the immediate generator. It also counts retired instructions and raises a sticky trap on an illegal opcode or a memory timeout.

Parameters:
TIMEOUT, 64, maximum cycles mem_req may stay high without mem_ready before trap (≥2)
CNT_W, 32, width of instret counter

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
opcode  in  7  IR[6:0] from datapath instruction register
funct3  in  3  IR[14:12]
rd_zero  in  1  IR[11:7]==0
branch_taken  in  1  comparator result for current branch (valid in EXEC)
mem_ready  in  1  memory completes request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  write strobe qualifier (store)
addr_sel  out  1  0=PC, 1=ALU result
ir_we  out  1  load IR and old_pc from memory/PC
pc_we  out  1  PC write enable
pc_sel  out  2  0=PC+4, 1=ALU target, 2=ALU target & ~1 (JALR)
alu_src_a  out  1  0=rs1, 1=old_pc
alu_src_b  out  1  0=rs2, 1=immediate
imm_sel  out  3  imm_fmt_t to immediate generator
reg_we  out  1  register-file write
wb_sel  out  2  0=ALU, 1=mem data, 2=old_pc+4, 3=immediate (LUI)
trap  out  1  sticky fault flag
instret  out  CNT_W  retired-instruction count

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset → FETCH, wait counter=0, instret=0, trap=0. All enables are 0 in the reset cycle and the cycle after.
- Outputs are decoded from state plus the registered IR fields. No output is driven combinationally from mem_ready except ir_we, pc_we and reg_we qualification as stated below.
- FETCH: mem_req=1, addr_sel=0, mem_we=0. On mem_ready: ir_we=1, pc_we=1, pc_sel=0, next state DECODE. Otherwise hold.
- DECODE: one cycle; register read. Legal opcodes: 0000011, 0100011, 0010011, 0110011, 1100011, 1101111, 1100111, 0110111, 0010111. An illegal opcode goes to TRAP; all others go to EXEC.
- EXEC, by opcode:
  - Load/store: alu_src_a=0, alu_src_b=1, imm I/S; next state MEM.
  - OP-IMM/OP: imm I; next state WB.
  - Branch: alu_src_a=1, imm B, pc_we=branch_taken, pc_sel=1; next state FETCH (retires).
  - JAL: src_a=1, imm J, pc_we=1, pc_sel=1; next state WB.
  - JALR: src_a=0, imm I, pc_we=1, pc_sel=2; next state WB.
  - LUI: imm U; next state WB.
  - AUIPC: src_a=1, imm U; next state WB.
- MEM: mem_req=1, addr_sel=1, mem_we=(store). On mem_ready, a load goes to WB and a store goes to FETCH (retires).
- WB: reg_we=~rd_zero; wb_sel is ALU, mem, old_pc+4 (JAL/JALR) or imm (LUI); next state FETCH (retires).
- Retire: instret += 1 on the cycle of any transition into FETCH from EXEC/MEM/WB. The counter wraps modulo 2^CNT_W.
- Latency with zero-wait memory (mem_ready in the first request cycle):
  - branch: 3 cycles
  - ALU/LUI/AUIPC/JAL/JALR/store: 4 cycles
  - load: 5 cycles
- Each memory wait cycle adds 1.
- Wait counter:
  - Cleared on entry to FETCH/MEM.
  - Increments each cycle mem_req=1 && !mem_ready.
  - Reaching TIMEOUT goes to TRAP.
- mem_ready while mem_req=0 is ignored.
- TRAP: all enables 0, mem_req=0, trap=1. The state holds until rst.
- rst asserted in any state, including mid-MEM with mem_req high, wins that edge. mem_req is low in the next cycle and any pending mem_ready is ignored.

Decomposition:
- Package rv_ctrl_pkg:
  - ctrl_state_t enum
  - imm_fmt_t {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J}
  - opcode constants OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC
  - pc_sel and wb_sel encodings
- One sub-module, rv_opcode_decode: combinational opcode → {legal, class, imm_fmt}. It is shared by DECODE/EXEC/WB output logic.

Test Plan:
- addi (opcode 0010011, rd=5), mem_ready in the same cycle as mem_req → states F,D,E,W. ir_we and pc_we in cycle 1; reg_we in cycle 4; instret 0→1.
- lw with mem_ready delayed 3 cycles in MEM → mem_req held for 4 MEM cycles with addr_sel=1, mem_we=0. wb_sel=1, reg_we=1. Total 8 cycles.
- beq with branch_taken=1, then again with branch_taken=0 → pc_we=1, pc_sel=1 in EXEC for the first; pc_we=0 for the second. Both return to FETCH, instret +2, no reg_we.
- Opcode 0000000 → TRAP after DECODE. trap=1 and all enables 0 for 20 cycles; rst clears trap and restarts FETCH.
- TIMEOUT=8, mem_ready held low in FETCH → trap asserted exactly 8 cycles after mem_req rose.
- rst pulsed during MEM of sw with mem_req=1 → next cycle state FETCH, mem_we=0, instret=0. A late mem_ready arriving in that cycle does not set ir_we.
